output_backprop_seq: RTL

Parametrised, multi-weight successor to the single-weight output-layer backprop unit. It captures target, network output, N hidden activations and N current weights on a start handshake. It then updates one weight per cycle with a signed, shift-scaled, saturating gradient step. The block sits between the top-level sequencer (which drives start_i while in the backward pass) and the output-neuron weight registers. It returns the packed updated weight vector with a done pulse.

---
 rtl/backprop_pkg.sv | 37 +++
 rtl/output_backprop_seq_weight_step.sv | 37 +++
 rtl/output_backprop_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/backprop_pkg.sv
// Shared types and helpers for the output-layer
// weight update sequencer.
package backprop_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_DONE
  } state_e;

  // err = x - final needs one bit beyond the output width
  function automatic int err_width(input int f_w);
    return f_w + 1;
  endfunction

  // err * h plus headroom for the doubling shift
  function automatic int prod_width(input int f_w,
                                    input int h_w);
    return f_w + h_w + 2;
  endfunction

  // Clamp a wide signed value into a w-bit signed range
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/output_backprop_seq_weight_step.sv
// One saturating gradient step for a single weight.
// Purely combinational; shared across all indices.
module weight_step
  import backprop_pkg::*;
#(
  parameter int W_WIDTH  = 8,
  parameter int H_WIDTH  = 10,
  parameter int ERR_W    = 24,
  parameter int PROD_W   = 35,
  parameter int LR_SHIFT = 8
) (
  input  logic signed [ERR_W-1:0]   err_i,
  input  logic        [H_WIDTH-1:0] h_i,
  input  logic signed [W_WIDTH-1:0] w_i,
  output logic signed [W_WIDTH-1:0] w_new_o
);

  logic signed [PROD_W-1:0] err_x;
  logic signed [PROD_W-1:0] h_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] delta;
  logic signed [PROD_W:0]   diff;
  logic signed [63:0]       diff_x;

  // delta = floor(2*err*h / 2^LR_SHIFT); w - delta clamped
  always_comb begin
    err_x = {{(PROD_W-ERR_W){err_i[ERR_W-1]}}, err_i};
    h_x   = {{(PROD_W-H_WIDTH){1'b0}}, h_i};
    prod  = err_x * h_x;
    delta = (prod <<< 1) >>> LR_SHIFT;
    diff  = $signed({{(PROD_W+1-W_WIDTH){w_i[W_WIDTH-1]}}, w_i})
          - $signed({delta[PROD_W-1], delta});
    diff_x = {{(63-PROD_W){diff[PROD_W]}}, diff};
    w_new_o = W_WIDTH'(saturate(diff_x, W_WIDTH));
  end

endmodule

// File: rtl/output_backprop_seq.sv
// Output-layer backprop sequencer: captures a pass,
// then updates one weight per cycle via weight_step.
module output_backprop_seq
  import backprop_pkg::*;
#(
  parameter int N_HIDDEN = 4,
  parameter int W_WIDTH  = 8,
  parameter int X_WIDTH  = 4,
  parameter int F_WIDTH  = 23,
  parameter int H_WIDTH  = 10,
  parameter int LR_SHIFT = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [X_WIDTH-1:0]            x_i,
  input  logic [F_WIDTH-1:0]            final_i,
  input  logic [N_HIDDEN*H_WIDTH-1:0]   hidden_val_i,
  input  logic [N_HIDDEN*W_WIDTH-1:0]   w_i,
  input  logic                          zero_weight_reset_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          valid_o,
  output logic [N_HIDDEN*W_WIDTH-1:0]   w_o
);

  localparam int ERR_W  = err_width(F_WIDTH);
  localparam int PROD_W = prod_width(F_WIDTH, H_WIDTH);
  localparam int IDX_W  =
    (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_HIDDEN - 1);

  state_e                    state_q, state_d;
  logic [X_WIDTH-1:0]        x_q, x_d;
  logic [F_WIDTH-1:0]        f_q, f_d;
  logic [H_WIDTH-1:0]        h_q [N_HIDDEN];
  logic [H_WIDTH-1:0]        h_d [N_HIDDEN];
  logic signed [W_WIDTH-1:0] w_q [N_HIDDEN];
  logic signed [W_WIDTH-1:0] w_d [N_HIDDEN];
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      valid_q, valid_d;
  logic signed [W_WIDTH-1:0] w_step;

  weight_step #(
    .W_WIDTH  (W_WIDTH),
    .H_WIDTH  (H_WIDTH),
    .ERR_W    (ERR_W),
    .PROD_W   (PROD_W),
    .LR_SHIFT (LR_SHIFT)
  ) u_step (
    .err_i   (err_q),
    .h_i     (h_q[idx_q]),
    .w_i     (w_q[idx_q]),
    .w_new_o (w_step)
  );

  // Next-state: clear, capture, error, per-index update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    f_d     = f_q;
    h_d     = h_q;
    w_d     = w_q;
    err_d   = err_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (zero_weight_reset_i) begin
      state_d = S_IDLE;
      x_d     = '0;
      f_d     = '0;
      for (int k = 0; k < N_HIDDEN; k++) begin
        h_d[k] = '0;
        w_d[k] = '0;
      end
      err_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            x_d = x_i;
            f_d = final_i;
            for (int k = 0; k < N_HIDDEN; k++) begin
              h_d[k] = hidden_val_i[k*H_WIDTH +: H_WIDTH];
              w_d[k] = w_i[k*W_WIDTH +: W_WIDTH];
            end
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          err_d = $signed(ERR_W'(x_q))
                - $signed(ERR_W'(f_q));
          idx_d   = '0;
          state_d = S_UPDATE;
        end
        S_UPDATE: begin
          w_d[idx_q] = w_step;
          if (idx_q == LAST) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      f_q     <= '0;
      for (int k = 0; k < N_HIDDEN; k++) begin
        h_q[k] <= '0;
        w_q[k] <= '0;
      end
      err_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      f_q     <= f_d;
      h_q     <= h_d;
      w_q     <= w_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign valid_o = valid_q;

  for (genvar g = 0; g < N_HIDDEN; g++) begin : g_wo
    assign w_o[g*W_WIDTH +: W_WIDTH] = w_q[g];
  end

endmodule
